// File: rtl/fir_input_loader.sv
// rtl/fir_input_loader.sv - nibble-serial sample/coefficient loader feeding the FIR tap delay line
// Optional parity checking on din is enabled by defining FIR_LOADER_PARITY_EN.
module fir_input_loader #(
  parameter int N_TAPS  = 2,
  parameter int BW_IN   = 8,
  parameter int BW_COEF = 8,
  parameter int NIB     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef FIR_LOADER_PARITY_EN
  input  logic                      par,
  output logic                      par_err,
`endif
  input  logic [NIB-1:0]            din,
  input  logic                      strobe,
  input  logic                      mode,
  input  logic                      clr,
  output logic [BW_IN-1:0]          x_out,
  output logic                      x_valid,
  output logic [N_TAPS*BW_COEF-1:0] coef_flat,
  output logic                      coef_done,
  output logic                      busy
);

  localparam int SAMP_CH = BW_IN / NIB;
  localparam int COEF_CH = BW_COEF / NIB;
  localparam int MAX_CH  = (SAMP_CH > COEF_CH) ? SAMP_CH : COEF_CH;
  localparam int AW      = MAX_CH * NIB;
  localparam int CW      = $clog2(MAX_CH + 1);
  localparam int IW      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CW-1:0] SAMP_LAST = CW'(SAMP_CH);
  localparam logic [CW-1:0] COEF_LAST = CW'(COEF_CH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, COEF} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [AW-1:0]               r_acc;
  logic [CW-1:0]               r_cnt;
  logic [IW-1:0]               r_idx;
  logic [BW_IN-1:0]            r_x;
  logic                        r_xv;
  logic [N_TAPS*BW_COEF-1:0]   r_coef;
  logic                        r_done;
  logic                        r_busy;

  logic                        w_take;
  logic                        w_last;
  logic                        w_is_coef;
  logic [CW-1:0]               w_cnt_next;
  logic [AW-1:0]               w_acc_next;
  logic                        w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // The first chunk decides the word type; later mode changes are ignored.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_is_coef    = 1'b0;
    case (r_state)
      IDLE: begin
        if (strobe) begin
          w_take       = 1'b1;
          w_is_coef    = mode;
          w_state_next = mode ? COEF : SAMPLE;
        end
      end
      SAMPLE: w_take = strobe;
      COEF: begin
        w_take    = strobe;
        w_is_coef = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
    w_cnt_next = (r_state == IDLE) ? CW'(1) : r_cnt + CW'(1);
    w_acc_next = (r_state == IDLE) ? AW'(din) : AW'({r_acc, din});
    w_last     = w_take && (w_cnt_next == (w_is_coef ? COEF_LAST : SAMP_LAST));
    if (w_last) w_state_next = IDLE;
    if (clr) begin
      w_take       = 1'b0;
      w_last       = 1'b0;
      w_state_next = IDLE;
    end
  end

`ifdef FIR_LOADER_PARITY_EN
  logic r_bad;
  logic r_par_err;
  logic w_chunk_bad;
  assign w_chunk_bad = ^{par, din};
  assign w_drop      = w_chunk_bad | ((r_state != IDLE) & r_bad);
  assign par_err     = r_par_err;

  // r_bad remembers a bad chunk anywhere in the word in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bad     <= 1'b0;
      r_par_err <= 1'b0;
    end else if (clr) begin
      r_bad     <= 1'b0;
      r_par_err <= 1'b0;
    end else if (w_take) begin
      r_bad <= w_drop;
      if (w_chunk_bad) r_par_err <= 1'b1;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_x    <= '0;
      r_xv   <= 1'b0;
      r_coef <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_xv   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= (w_state_next != IDLE);
      if (clr) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_acc <= w_acc_next;
        r_cnt <= w_last ? '0 : w_cnt_next;
        if (w_last && !w_drop) begin
          if (w_is_coef) begin
            r_coef[r_idx*BW_COEF +: BW_COEF] <= w_acc_next[BW_COEF-1:0];
            if (r_idx == LAST_IDX) begin
              r_idx  <= '0;
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_x  <= w_acc_next[BW_IN-1:0];
            r_xv <= 1'b1;
          end
        end
      end
    end
  end

  assign x_out     = r_x;
  assign x_valid   = r_xv;
  assign coef_flat = r_coef;
  assign coef_done = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fir_input_loader.sv
// tb/tb_fir_input_loader.sv - directed table, reset/parity sequences and random run against a queue model
module tb_fir_input_loader;

  localparam int N_TAPS = 2, BW_IN = 8, BW_COEF = 8, NIB = 4;
  localparam int SAMP_CH = BW_IN / NIB, COEF_CH = BW_COEF / NIB;
`ifdef FIR_LOADER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NIB-1:0]            din;
  logic                      strobe, mode, clr;
  logic [BW_IN-1:0]          x_out;
  logic                      x_valid;
  logic [N_TAPS*BW_COEF-1:0] coef_flat;
  logic                      coef_done, busy;
`ifdef FIR_LOADER_PARITY_EN
  logic                      par, par_err;
`endif

  always #5 clk = ~clk;

  fir_input_loader #(.N_TAPS(N_TAPS), .BW_IN(BW_IN), .BW_COEF(BW_COEF), .NIB(NIB)) dut (
    .clk(clk), .reset(reset),
`ifdef FIR_LOADER_PARITY_EN
    .par(par), .par_err(par_err),
`endif
    .din(din), .strobe(strobe), .mode(mode), .clr(clr),
    .x_out(x_out), .x_valid(x_valid), .coef_flat(coef_flat),
    .coef_done(coef_done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a word is just the list of chunks received since it started.
  logic [3:0]  m_q[$];
  bit          m_in_word, m_wmode, m_xv, m_done, m_wbad, m_perr;
  logic [7:0]  m_x;
  logic [7:0]  m_coef[N_TAPS];
  int          m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_word = 0; m_wmode = 0; m_xv = 0; m_done = 0; m_wbad = 0; m_perr = 0;
    m_x = 0; m_idx = 0;
    for (int k = 0; k < N_TAPS; k++) m_coef[k] = 0;
  endtask

  task automatic model_step(input bit s, input logic [3:0] d, input bit md, input bit c, input bit p);
    int need;
    logic [15:0] word;
    m_xv = 0; m_done = 0;
    if (c) begin
      m_q.delete(); m_in_word = 0; m_wbad = 0; m_perr = 0;
    end else if (s) begin
      if (!m_in_word) begin
        m_in_word = 1; m_wmode = md; m_wbad = 0; m_q.delete();
      end
      if (PAR_ON && (^{p, d})) begin m_wbad = 1; m_perr = 1; end
      m_q.push_back(d);
      need = m_wmode ? COEF_CH : SAMP_CH;
      if (m_q.size() == need) begin
        word = 0;
        foreach (m_q[i]) word = (word << NIB) | 16'(m_q[i]);
        if (!m_wbad) begin
          if (m_wmode) begin
            m_coef[m_idx] = word[7:0];
            m_idx = (m_idx + 1) % N_TAPS;
            m_done = (m_idx == 0);
          end else begin
            m_x = word[7:0]; m_xv = 1;
          end
        end
        m_in_word = 0; m_q.delete();
      end
    end
  endtask

  task automatic step(input bit s, input logic [3:0] d, input bit md, input bit c, input bit p);
    strobe = s; din = d; mode = md; clr = c;
`ifdef FIR_LOADER_PARITY_EN
    par = p;
`endif
    @(posedge clk);
    model_step(s, d, md, c, p);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".x_out"},     32'(x_out),     32'(m_x));
    chk({tag, ".x_valid"},   32'(x_valid),   32'(m_xv));
    chk({tag, ".coef_flat"}, 32'(coef_flat), 32'({m_coef[1], m_coef[0]}));
    chk({tag, ".coef_done"}, 32'(coef_done), 32'(m_done));
    chk({tag, ".busy"},      32'(busy),      32'(m_in_word));
`ifdef FIR_LOADER_PARITY_EN
    chk({tag, ".par_err"},   32'(par_err),   32'(m_perr));
`endif
  endtask

  typedef struct {
    bit         s;
    logic [3:0] d;
    bit         md;
    bit         c;
    logic [7:0] ex;
    bit         exv;
    logic [15:0] ecoef;
    bit         edone;
    bit         ebusy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [3:0] rd;
    bit rs, rm, rc;

    //            s  din   md c  x_out  xv coef      done busy
    tbl[0]  = '{1, 4'hA, 0, 0, 8'h00, 0, 16'h0000, 0, 1};
    tbl[1]  = '{1, 4'h5, 0, 0, 8'hA5, 1, 16'h0000, 0, 0};
    tbl[2]  = '{0, 4'h0, 0, 0, 8'hA5, 0, 16'h0000, 0, 0};
    tbl[3]  = '{1, 4'h3, 1, 0, 8'hA5, 0, 16'h0000, 0, 1};
    tbl[4]  = '{1, 4'hC, 0, 0, 8'hA5, 0, 16'h003C, 0, 0};
    tbl[5]  = '{1, 4'h7, 1, 0, 8'hA5, 0, 16'h003C, 0, 1};
    tbl[6]  = '{1, 4'h1, 1, 0, 8'hA5, 0, 16'h713C, 1, 0};
    tbl[7]  = '{1, 4'h9, 1, 0, 8'hA5, 0, 16'h713C, 0, 1};
    tbl[8]  = '{1, 4'h9, 0, 0, 8'hA5, 0, 16'h7199, 0, 0};
    tbl[9]  = '{1, 4'hF, 0, 0, 8'hA5, 0, 16'h7199, 0, 1};
    tbl[10] = '{0, 4'h0, 0, 0, 8'hA5, 0, 16'h7199, 0, 1};
    tbl[11] = '{0, 4'h0, 1, 0, 8'hA5, 0, 16'h7199, 0, 1};
    tbl[12] = '{1, 4'h2, 0, 1, 8'hA5, 0, 16'h7199, 0, 0};
    tbl[13] = '{1, 4'h4, 0, 0, 8'hA5, 0, 16'h7199, 0, 1};
    tbl[14] = '{1, 4'h2, 1, 0, 8'h42, 1, 16'h7199, 0, 0};
    tbl[15] = '{1, 4'h6, 0, 0, 8'h42, 0, 16'h7199, 0, 1};
    tbl[16] = '{1, 4'h6, 0, 0, 8'h66, 1, 16'h7199, 0, 0};
    tbl[17] = '{1, 4'hB, 0, 0, 8'h66, 0, 16'h7199, 0, 1};
    tbl[18] = '{1, 4'hC, 0, 0, 8'hBC, 1, 16'h7199, 0, 0};

    reset = 1'b0; strobe = 0; din = 0; mode = 0; clr = 0;
`ifdef FIR_LOADER_PARITY_EN
    par = 0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rel.x_out",     32'(x_out),     32'h00);
    chk("rel.coef_flat", 32'(coef_flat), 32'h0000);
    chk("rel.x_valid",   32'(x_valid),   32'(0));
    chk("rel.coef_done", 32'(coef_done), 32'(0));
    chk("rel.busy",      32'(busy),      32'(0));

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].md, tbl[i].c, ^tbl[i].d);
      chk($sformatf("tbl%0d.x_out", i),     32'(x_out),     32'(tbl[i].ex));
      chk($sformatf("tbl%0d.x_valid", i),   32'(x_valid),   32'(tbl[i].exv));
      chk($sformatf("tbl%0d.coef_flat", i), 32'(coef_flat), 32'(tbl[i].ecoef));
      chk($sformatf("tbl%0d.coef_done", i), 32'(coef_done), 32'(tbl[i].edone));
      chk($sformatf("tbl%0d.busy", i),      32'(busy),      32'(tbl[i].ebusy));
    end

    // Reset in the middle of a coefficient word takes effect without a clock edge.
    step(1, 4'h3, 1, 0, ^4'h3);
    chk("midrst.busy_before", 32'(busy), 32'(1));
    #2;
    strobe = 0;
    reset  = 1'b0;
    #1;
    model_reset();
    chk("midrst.x_out",     32'(x_out),     32'h00);
    chk("midrst.coef_flat", 32'(coef_flat), 32'h0000);
    chk("midrst.busy",      32'(busy),      32'(0));
    chk("midrst.x_valid",   32'(x_valid),   32'(0));
    @(negedge clk);
    reset = 1'b1;
    step(1, 4'hA, 0, 0, ^4'hA);
    chk("post.busy", 32'(busy), 32'(1));
    step(1, 4'h5, 0, 0, ^4'h5);
    chk("post.x_out", 32'(x_out), 32'hA5);
    chk("post.x_valid", 32'(x_valid), 32'(1));
    step(1, 4'h1, 1, 0, ^4'h1);
    step(1, 4'h2, 1, 0, ^4'h2);
    chk("post.coef_slot0", 32'(coef_flat), 32'h0012);
    chk_model("post");

`ifdef FIR_LOADER_PARITY_EN
    step(1, 4'h3, 0, 0, 1'b1);
    chk("par.err_set", 32'(par_err), 32'(1));
    step(1, 4'h0, 0, 0, 1'b0);
    chk("par.no_valid", 32'(x_valid), 32'(0));
    chk("par.x_out_kept", 32'(x_out), 32'hA5);
    chk("par.busy", 32'(busy), 32'(0));
    chk("par.err_sticky", 32'(par_err), 32'(1));
    step(0, 4'h0, 0, 1, 1'b0);
    chk("par.err_clr", 32'(par_err), 32'(0));
`endif

    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 9) < 7);
      rd = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 19) == 0);
      step(rs, rd, rm, rc, ^rd);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
